lag_measure: RTL

//  Measures display input lag: counts time from videogen's starttrigger pulse (first white test-field frame) to
//  the photo-sensor's rising edge, in microseconds, as packed BCD. Sits beside videogen: consumes starttrigger,

---
 rtl/lag_measure_pkg.sv | 45 ++++
 rtl/lag_measure_bcd_counter.sv | 39 +++
 rtl/lag_measure.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lag_measure_pkg.sv
// ---------------------------------------------------------------------------
// lag_measure_pkg
// Shared definitions for the display-lag measurement block: the FSM state
// encoding, the packed-BCD geometry of the lag readouts and a helper that
// advances a packed-BCD value by one with cascaded digit carry.
// No ports (package).
// ---------------------------------------------------------------------------
package lag_measure_pkg;

  // Six BCD digits laid out as mmm.uuu milliseconds
  localparam int LAG_BCD_DIGITS = 6;
  localparam int LAG_BCD_WIDTH  = 4 * LAG_BCD_DIGITS;
  localparam logic [LAG_BCD_WIDTH-1:0] LAG_BCD_MAX = 24'h999999;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEASURING = 2'd1,
    CONFIRM   = 2'd2,
    TIMEOUT   = 2'd3
  } lagState_t;

  // Adds one to a packed-BCD value. Each digit that sits at 9 rolls to 0 and
  // passes the carry on to the next digit up; the first digit below 9 absorbs
  // the carry. An all-nines value wraps to zero.
  function automatic logic [LAG_BCD_WIDTH-1:0] bcdIncrement(
    input logic [LAG_BCD_WIDTH-1:0] value
  );
    logic [LAG_BCD_WIDTH-1:0] result;
    logic                     carry;
    result = value;
    carry  = 1'b1;
    for (int d = 0; d < LAG_BCD_DIGITS; d++) begin
      if (carry) begin
        if (value[4*d +: 4] == 4'd9) begin
          result[4*d +: 4] = 4'd0;
        end else begin
          result[4*d +: 4] = value[4*d +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/lag_measure_bcd_counter.sv
// ---------------------------------------------------------------------------
// lag_measure_bcd_counter
// Six-digit cascaded BCD up-counter with synchronous clear and count enable.
// Used as the microsecond accumulator of the lag measurement and suitable for
// reuse wherever a decimal readout counter is needed.
// Ports:
//   i_clock    in   1   clock, rising edge
//   i_reset_n  in   1   synchronous active-low reset, count -> 0
//   i_clear    in   1   synchronous clear, wins over i_enable
//   i_enable   in   1   advance the count by one this cycle
//   o_count    out  24  current count, packed BCD
// ---------------------------------------------------------------------------
module lag_measure_bcd_counter
  import lag_measure_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_enable,
  output logic [LAG_BCD_WIDTH-1:0] o_count
);

  logic [LAG_BCD_WIDTH-1:0] r_count;

  // Count register: clear takes priority so a fresh measurement always
  // starts from zero even if a tick lands on the same cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= bcdIncrement(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/lag_measure.sv
// ---------------------------------------------------------------------------
// lag_measure
// Measures display input lag: the time from the start trigger (first white
// test-field frame) to the photo-sensor's confirmed rising edge, in whole
// microseconds as packed BCD (mmm.uuu ms). Keeps the last lag plus the
// minimum and maximum valid lag since reset or the last stats clear.
// Parameters:
//   CYCLES_PER_US    clock cycles per microsecond tick (>= 2)
//   DEBOUNCE_CYCLES  cycles the synced sensor must stay high to confirm (>= 1)
//   TIMEOUT_BCD      counter value at which a measurement is abandoned
// Ports:
//   i_clock         in   1   pixel clock, rising edge
//   i_reset_n       in   1   synchronous active-low reset
//   i_starttrigger  in   1   one-cycle pulse, starts a measurement
//   i_sensor        in   1   raw asynchronous photo-sensor, 1 = light
//   i_clear_stats   in   1   one-cycle pulse, resets min/max
//   o_busy          out  1   high while measuring
//   o_lag_valid     out  1   one-cycle pulse, o_lag_bcd just updated
//   o_lag_timeout   out  1   one-cycle pulse, measurement abandoned
//   o_lag_bcd       out  24  last measured lag
//   o_lag_min_bcd   out  24  smallest valid lag
//   o_lag_max_bcd   out  24  largest valid lag
// ---------------------------------------------------------------------------
module lag_measure
  import lag_measure_pkg::*;
#(
  parameter int                       CYCLES_PER_US   = 74,
  parameter int                       DEBOUNCE_CYCLES = 16,
  parameter logic [LAG_BCD_WIDTH-1:0] TIMEOUT_BCD     = LAG_BCD_MAX
)(
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_starttrigger,
  input  logic                     i_sensor,
  input  logic                     i_clear_stats,
  output logic                     o_busy,
  output logic                     o_lag_valid,
  output logic                     o_lag_timeout,
  output logic [LAG_BCD_WIDTH-1:0] o_lag_bcd,
  output logic [LAG_BCD_WIDTH-1:0] o_lag_min_bcd,
  output logic [LAG_BCD_WIDTH-1:0] o_lag_max_bcd
);

  localparam int PRESCALE_W = $clog2(CYCLES_PER_US);
  localparam int DEBOUNCE_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(CYCLES_PER_US - 1);
  localparam logic [DEBOUNCE_W-1:0] DEBOUNCE_DONE = DEBOUNCE_W'(DEBOUNCE_CYCLES);

  lagState_t r_state;
  lagState_t w_nextState;

  logic                     r_syncMeta;
  logic                     r_syncSensor;
  logic                     r_syncDelayed;
  logic                     w_sensorEdge;

  logic [PRESCALE_W-1:0]    r_prescaler;
  logic                     w_tick;
  logic [LAG_BCD_WIDTH-1:0] w_count;

  logic                     r_capPending;
  logic [LAG_BCD_WIDTH-1:0] r_capture;
  logic [DEBOUNCE_W-1:0]    r_debounce;
  logic [DEBOUNCE_W-1:0]    w_debounceNext;
  logic                     w_captureNow;
  logic                     w_debounceStep;
  logic                     w_hitConfirmed;
  logic                     w_startMeasure;

  logic                     w_busy;
  logic                     w_loadResult;
  logic                     w_abort;

  logic                     r_lagValid;
  logic                     r_lagTimeout;
  logic [LAG_BCD_WIDTH-1:0] r_lagBcd;
  logic [LAG_BCD_WIDTH-1:0] r_lagMinBcd;
  logic [LAG_BCD_WIDTH-1:0] r_lagMaxBcd;

  // Two-flop synchroniser for the asynchronous sensor plus one more stage so
  // a rising edge can be seen. The synchroniser delay is part of the lag.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_syncMeta    <= 1'b0;
      r_syncSensor  <= 1'b0;
      r_syncDelayed <= 1'b0;
    end else begin
      r_syncMeta    <= i_sensor;
      r_syncSensor  <= r_syncMeta;
      r_syncDelayed <= r_syncSensor;
    end
  end

  assign w_sensorEdge = r_syncSensor & ~r_syncDelayed;

  // Triggers are only honoured from IDLE; a trigger while busy is dropped
  // and a sensor edge on the trigger cycle is never captured.
  assign w_startMeasure = (r_state == IDLE) && i_starttrigger;

  // Capture/debounce decisions. An edge only captures when nothing is
  // pending; the debounce count starts at 1 on the capturing cycle so that
  // a hit confirms after DEBOUNCE_CYCLES cycles of high synced sensor.
  assign w_captureNow   = (r_state == MEASURING) && !r_capPending && w_sensorEdge;
  assign w_debounceStep = (r_state == MEASURING) && r_capPending && r_syncSensor;
  assign w_debounceNext = w_captureNow ? DEBOUNCE_W'(1) : (r_debounce + DEBOUNCE_W'(1));
  assign w_hitConfirmed = (w_captureNow || w_debounceStep) && (w_debounceNext == DEBOUNCE_DONE);

  // Prescaler. The trigger cycle itself counts as slot 0, so the register
  // loads 1 on the trigger edge; this makes the microsecond count equal to
  // floor(cycles since trigger / CYCLES_PER_US). Held at zero when idle.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_prescaler <= '0;
    end else if (w_startMeasure) begin
      r_prescaler <= PRESCALE_W'(1);
    end else if (r_state == MEASURING) begin
      r_prescaler <= w_tick ? '0 : (r_prescaler + PRESCALE_W'(1));
    end else begin
      r_prescaler <= '0;
    end
  end

  assign w_tick = (r_state == MEASURING) && (r_prescaler == PRESCALE_LAST);

  lag_measure_bcd_counter u_usCounter (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (w_startMeasure),
    .i_enable  (w_tick),
    .o_count   (w_count)
  );

  // Capture and debounce state. A pending capture that sees the synced
  // sensor drop is discarded and the search for the next edge carries on.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_capPending <= 1'b0;
      r_capture    <= '0;
      r_debounce   <= '0;
    end else if (w_startMeasure) begin
      r_capPending <= 1'b0;
      r_capture    <= '0;
      r_debounce   <= '0;
    end else if (w_captureNow) begin
      r_capPending <= 1'b1;
      r_capture    <= w_count;
      r_debounce   <= w_debounceNext;
    end else if (w_debounceStep) begin
      r_debounce   <= w_debounceNext;
    end else if ((r_state == MEASURING) && r_capPending) begin
      r_capPending <= 1'b0;
      r_debounce   <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state logic. A hit confirmed on the same cycle the counter
  // reaches the timeout value still counts as a hit.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_starttrigger) begin
          w_nextState = MEASURING;
        end
      end
      MEASURING: begin
        if (w_hitConfirmed) begin
          w_nextState = CONFIRM;
        end else if (w_count == TIMEOUT_BCD) begin
          w_nextState = TIMEOUT;
        end
      end
      CONFIRM: w_nextState = IDLE;
      TIMEOUT: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state.
  always_comb begin
    w_busy       = 1'b0;
    w_loadResult = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      MEASURING: w_busy       = 1'b1;
      CONFIRM:   w_loadResult = 1'b1;
      TIMEOUT:   w_abort      = 1'b1;
      default: begin
        w_busy       = 1'b0;
        w_loadResult = 1'b0;
        w_abort      = 1'b0;
      end
    endcase
  end

  // Result and statistics registers. Packed BCD compares correctly as an
  // unsigned number. A stats clear coinciding with a result is applied
  // first, so the new lag seeds both min and max.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_lagValid   <= 1'b0;
      r_lagTimeout <= 1'b0;
      r_lagBcd     <= '0;
      r_lagMinBcd  <= LAG_BCD_MAX;
      r_lagMaxBcd  <= '0;
    end else begin
      r_lagValid   <= w_loadResult;
      r_lagTimeout <= w_abort;
      if (w_loadResult) begin
        r_lagBcd <= r_capture;
      end
      if (w_loadResult && i_clear_stats) begin
        r_lagMinBcd <= r_capture;
        r_lagMaxBcd <= r_capture;
      end else if (w_loadResult) begin
        if (r_capture < r_lagMinBcd) begin
          r_lagMinBcd <= r_capture;
        end
        if (r_capture > r_lagMaxBcd) begin
          r_lagMaxBcd <= r_capture;
        end
      end else if (i_clear_stats) begin
        r_lagMinBcd <= LAG_BCD_MAX;
        r_lagMaxBcd <= '0;
      end
    end
  end

  assign o_busy        = w_busy;
  assign o_lag_valid   = r_lagValid;
  assign o_lag_timeout = r_lagTimeout;
  assign o_lag_bcd     = r_lagBcd;
  assign o_lag_min_bcd = r_lagMinBcd;
  assign o_lag_max_bcd = r_lagMaxBcd;

endmodule
